// File: rtl/argmax_classifier.sv
// argmax_classifier: sequential signed argmax over N_CLASSES snapshotted scores.
// Optional top-minus-second margin output enabled by macro ARGMAX_MARGIN_EN. Rev 1.0
`default_nettype none

module argmax_classifier #(
  parameter int N_CLASSES = 2,
  parameter int DATA_W    = 32,
  parameter int IDX_W     = 8
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] scores [0:N_CLASSES-1],
  input  logic                     start,
  output logic        [IDX_W-1:0]  result,
  output logic signed [DATA_W-1:0] max_score,
  output logic signed [DATA_W-1:0] margin,
  output logic                     busy,
  output logic                     done
);

  localparam int CNT_W = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_CLASSES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DONE  = 2'd2,
    REARM = 2'd3
  } state_t;

  state_t                   state;
  logic        [CNT_W-1:0]  idx;
  logic signed [DATA_W-1:0] snap [0:N_CLASSES-1];
  logic signed [DATA_W-1:0] best;
  logic        [IDX_W-1:0]  best_idx;

  logic signed [DATA_W-1:0] cur;
  logic                     take;
  logic signed [DATA_W-1:0] nxt_best;
  logic        [IDX_W-1:0]  nxt_idx;

`ifdef ARGMAX_MARGIN_EN
  localparam logic signed [DATA_W-1:0] MARGIN_MAX = {1'b0, {(DATA_W-1){1'b1}}};

  logic signed [DATA_W-1:0] second;
  logic signed [DATA_W-1:0] nxt_second;
  logic        [DATA_W:0]   diff;
  logic signed [DATA_W-1:0] margin_nxt;
`endif

  // Evaluate the element under the cursor against the running best.
  always_comb begin
    cur      = snap[idx];
    take     = (idx == '0) || (cur > best);
    nxt_best = take ? cur : best;
    nxt_idx  = take ? IDX_W'(idx) : best_idx;
`ifdef ARGMAX_MARGIN_EN
    nxt_second = second;
    if (take) begin
      nxt_second = best;
    end else if ((cur > second) || (idx == CNT_W'(1))) begin
      nxt_second = cur;
    end
    // best >= second once two elements are seen, so only positive overflow is possible.
    diff = {nxt_best[DATA_W-1], nxt_best} - {nxt_second[DATA_W-1], nxt_second};
    if (N_CLASSES == 1) begin
      margin_nxt = MARGIN_MAX;
    end else if (diff[DATA_W:DATA_W-1] == 2'b01) begin
      margin_nxt = MARGIN_MAX;
    end else begin
      margin_nxt = diff[DATA_W-1:0];
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      best      <= '0;
      best_idx  <= '0;
      result    <= '0;
      max_score <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < N_CLASSES; i++) begin
        snap[i] <= '0;
      end
`ifdef ARGMAX_MARGIN_EN
      second    <= '0;
      margin    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < N_CLASSES; i++) begin
              snap[i] <= scores[i];
            end
            idx   <= '0;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end
        SCAN: begin
          best     <= nxt_best;
          best_idx <= nxt_idx;
`ifdef ARGMAX_MARGIN_EN
          second   <= nxt_second;
`endif
          if (idx == LAST) begin
            result    <= nxt_idx;
            max_score <= nxt_best;
`ifdef ARGMAX_MARGIN_EN
            margin    <= margin_nxt;
`endif
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          state <= REARM;
        end
        REARM: begin
          // A start level held high must not retrigger; wait for it to drop.
          if (!start) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef ARGMAX_MARGIN_EN
  assign margin = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_argmax_classifier.sv
// Randomized self-checking bench for argmax_classifier at N_CLASSES = 10, 4, 2, 1.
`default_nettype none

module tb_argmax_classifier;

  localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic st [4];
  logic signed [31:0] sc10 [0:9];
  logic signed [31:0] sc4  [0:3];
  logic signed [31:0] sc2  [0:1];
  logic signed [31:0] sc1  [0:0];
  logic        [7:0]  res  [4];
  logic signed [31:0] mx   [4];
  logic signed [31:0] mg   [4];
  logic               bs   [4];
  logic               dn   [4];

  int n_checks = 0;
  int n_pass   = 0;
  int ncls [4] = '{10, 4, 2, 1};
  logic [7:0]  prev_res [4];

  argmax_classifier #(.N_CLASSES(10), .DATA_W(32), .IDX_W(8)) u10 (
    .CLK(clk), .reset(reset), .scores(sc10), .start(st[0]), .result(res[0]),
    .max_score(mx[0]), .margin(mg[0]), .busy(bs[0]), .done(dn[0]));
  argmax_classifier #(.N_CLASSES(4), .DATA_W(32), .IDX_W(8)) u4 (
    .CLK(clk), .reset(reset), .scores(sc4), .start(st[1]), .result(res[1]),
    .max_score(mx[1]), .margin(mg[1]), .busy(bs[1]), .done(dn[1]));
  argmax_classifier #(.N_CLASSES(2), .DATA_W(32), .IDX_W(8)) u2 (
    .CLK(clk), .reset(reset), .scores(sc2), .start(st[2]), .result(res[2]),
    .max_score(mx[2]), .margin(mg[2]), .busy(bs[2]), .done(dn[2]));
  argmax_classifier #(.N_CLASSES(1), .DATA_W(32), .IDX_W(8)) u1 (
    .CLK(clk), .reset(reset), .scores(sc1), .start(st[3]), .result(res[3]),
    .max_score(mx[3]), .margin(mg[3]), .busy(bs[3]), .done(dn[3]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic set_sc(input int k, input int i, input logic signed [31:0] v);
    case (k)
      0: sc10[i] = v;
      1: sc4[i]  = v;
      2: sc2[i]  = v;
      default: sc1[0] = v;
    endcase
  endtask

  // Reference: first occurrence of the maximum; second-best is the max of
  // the remaining multiset after removing that one occurrence.
  function automatic void model(input int n, input logic signed [31:0] v [10],
                                output logic [7:0] eidx, output logic [31:0] emx,
                                output logic [31:0] emg);
    int bi = 0;
    longint sec;
    longint d;
    for (int i = 1; i < n; i++) if (v[i] > v[bi]) bi = i;
    eidx = 8'(bi);
    emx  = v[bi];
    if (n == 1) begin
      emg = SAT_MAX;
    end else begin
      sec = -(64'sd1 <<< 40);
      for (int j = 0; j < n; j++) if (j != bi && longint'(v[j]) > sec) sec = longint'(v[j]);
      d = longint'(v[bi]) - sec;
      emg = (d > longint'(SAT_MAX)) ? SAT_MAX : 32'(d);
    end
`ifndef ARGMAX_MARGIN_EN
    emg = '0;
`endif
  endfunction

  task automatic run(input int k, input logic signed [31:0] v [10], input int hold,
                     input bit mutate, input string tag);
    int n = ncls[k];
    int lat = -1;
    int pulses = 0;
    logic [7:0]  eidx;
    logic [31:0] emx, emg;
    model(n, v, eidx, emx, emg);
    for (int i = 0; i < n; i++) set_sc(k, i, v[i]);
    st[k] = 1'b1;
    for (int c = 1; c <= n + hold + 6; c++) begin
      @(posedge clk); #1;
      if (c == hold) st[k] = 1'b0;
      if (c == 1) begin
        chk({tag, "_busy"}, 32'(bs[k]), 32'd1);
        chk({tag, "_hold_scan"}, 32'(res[k]), 32'(prev_res[k]));
      end
      if (mutate && c == 2) begin
        for (int i = 0; i < n; i++) set_sc(k, i, 32'sd9);
        st[k] = 1'b1;
      end
      if (mutate && c == 3) st[k] = 1'b0;
      if (dn[k] === 1'b1) begin
        pulses++;
        if (lat < 0) begin
          lat = c;
          chk({tag, "_result"}, 32'(res[k]), 32'(eidx));
          chk({tag, "_max"}, mx[k], emx);
          chk({tag, "_margin"}, mg[k], emg);
        end
      end
    end
    chk({tag, "_latency"}, 32'(lat), 32'(n + 1));
    chk({tag, "_pulses"}, 32'(pulses), 32'd1);
    chk({tag, "_held"}, 32'(res[k]), 32'(eidx));
    prev_res[k] = eidx;
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_res%0d", tag, k), 32'(res[k]), 32'd0);
      chk($sformatf("%s_max%0d", tag, k), mx[k], 32'd0);
      chk($sformatf("%s_mg%0d", tag, k), mg[k], 32'd0);
      chk($sformatf("%s_busy%0d", tag, k), 32'(bs[k]), 32'd0);
      chk($sformatf("%s_done%0d", tag, k), 32'(dn[k]), 32'd0);
      prev_res[k] = '0;
    end
  endtask

  initial begin
    logic signed [31:0] v [10];
    int pulses;
    reset = 1'b1;
    for (int k = 0; k < 4; k++) st[k] = 1'b0;
    for (int i = 0; i < 10; i++) sc10[i] = '0;
    for (int i = 0; i < 4; i++) sc4[i] = '0;
    sc2[0] = '0; sc2[1] = '0; sc1[0] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("rst");
    reset = 1'b0;

    v = '{32'sd5, 32'sd3, 0, 0, 0, 0, 0, 0, 0, 0};
    run(2, v, 10, 1'b0, "n2_held_start");

    v = '{-32'sd1, -32'sd7, 32'sd4, 32'sd4, -32'sd2, 32'sd0, 32'sd3, 32'sd1, 32'sd2, -32'sd8};
    run(0, v, 1, 1'b0, "n10_tie");

    for (int i = 0; i < 10; i++) v[i] = 32'sh8000_0000;
    run(1, v, 1, 1'b0, "n4_allmin");

    v = '{32'sh7FFF_FFFF, 32'sh8000_0000, 0, 0, 0, 0, 0, 0, 0, 0};
    run(2, v, 1, 1'b0, "n2_sat");

    v = '{-32'sd3, 32'sd2, -32'sd5, 32'sd1, 0, 0, 0, 0, 0, 0};
    run(1, v, 1, 1'b1, "n4_snapshot");

    v[0] = -32'sd42;
    run(3, v, 3, 1'b0, "n1");

    // Abort mid-scan with reset, then a fresh classification.
    for (int i = 0; i < 10; i++) sc10[i] = 32'($urandom);
    st[0] = 1'b1;
    pulses = 0;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      if (c == 1) st[0] = 1'b0;
      if (dn[0] === 1'b1) pulses++;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_zero("abort");
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (dn[0] === 1'b1) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);
    for (int i = 0; i < 10; i++) v[i] = 32'($urandom);
    run(0, v, 1, 1'b0, "after_abort");

    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < 10; i++) begin
        if (r % 3 == 0) v[i] = 32'($urandom_range(0, 6)) - 32'sd3;
        else v[i] = 32'($urandom);
      end
      run(r % 4, v, 1 + (r % 3), 1'b0, $sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
